uart_pkt_wrapper: RTL and testbench

Parametrised packet layer between a byte-level UART (rx/tx) and the command processor. It assembles CMD_BYTES received bytes, MSB first, into one command word with a ready flag. It also serialises a RESP_BYTES response, MSB first, into the UART transmitter. Over the fixed 2-byte command / 1-byte response wrapper it adds three things: an inter-byte timeout with frame resync, an overrun flag, and multi-byte responses.

---
 rtl/uart_pkt_pkg.sv | 5 +
 rtl/pkt_tx_serializer.sv | 47 ++++
 rtl/uart_pkt_wrapper.sv | 78 +++++++
 tb/tb_uart_pkt_wrapper.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: FSM state types shared by the UART packet wrapper and its serializer
package uart_pkt_pkg;
    typedef enum logic {IDLE, ASSEMBLE} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
endpackage

// File: rtl/pkt_tx_serializer.sv
// pkt_tx_serializer: sends a latched multi-byte response MSB first, one byte per UART handshake
module pkt_tx_serializer
    import uart_pkt_pkg::*;
#(
    parameter int RESP_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trmt,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    tx_byte_done,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    output logic                    tx_done
);
    localparam int IW = RESP_BYTES > 1 ? $clog2(RESP_BYTES) : 1;
    tx_state_t state, nxt;
    logic [8*RESP_BYTES-1:0] resp_q;
    logic [IW-1:0] idx;
    logic last;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= TX_IDLE;
        else state <= nxt;
    always_comb begin
        last = idx == IW'(RESP_BYTES - 1);
        nxt = state == TX_IDLE ? (trmt ? TX_SEND : TX_IDLE) :
              state == TX_SEND ? TX_WAIT :
              tx_byte_done ? (last ? TX_IDLE : TX_SEND) : TX_WAIT;
    end
    always_comb begin
        tx_start = state == TX_SEND;
        tx_data = resp_q[8*(RESP_BYTES-1-int'(idx)) +: 8];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            resp_q <= '0;
            idx <= '0;
            tx_done <= 1'b0;
        end else if (state == TX_IDLE && trmt) begin
            resp_q <= resp;
            idx <= '0;
            tx_done <= 1'b0;
        end else if (state == TX_WAIT && tx_byte_done) begin
            tx_done <= last;
            idx <= last ? idx : idx + 1'b1;
        end
endmodule

// File: rtl/uart_pkt_wrapper.sv
// uart_pkt_wrapper: assembles UART bytes into commands (with timeout resync/overrun) and serializes responses
module uart_pkt_wrapper
    import uart_pkt_pkg::*;
#(
    parameter int CMD_BYTES   = 2,
    parameter int RESP_BYTES  = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    output logic                    clr_rx_rdy,
    output logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    cmd_rdy,
    input  logic                    clr_cmd_rdy,
    output logic                    overrun,
    output logic                    frm_err,
    input  logic                    trmt,
    input  logic [8*RESP_BYTES-1:0] resp,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_byte_done,
    output logic                    tx_done
);
    localparam int CW = 8 * CMD_BYTES;
    localparam int BW = $clog2(CMD_BYTES + 1);
    localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    rx_state_t state, nxt;
    logic [CW-1:0] shift, word;
    logic [BW-1:0] cnt, base;
    logic [TW-1:0] tcnt;
    logic unread, expire, first, complete;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    always_comb nxt = (rx_rdy && !complete) ? ASSEMBLE : (expire || complete) ? IDLE : state;
    // A byte landing on the expiry cycle restarts from count 0 rather than joining the stale frame
    always_comb begin
        clr_rx_rdy = rx_rdy;
        expire = TIMEOUT_CYC != 0 && state == ASSEMBLE && tcnt == TW'(TIMEOUT_CYC);
        base = expire ? '0 : cnt;
        complete = rx_rdy && base == BW'(CMD_BYTES - 1);
        first = rx_rdy && base == '0 && !complete;
        word = CW'({shift, rx_data});
    end
    // unread tracks an uncollected command even after cmd_rdy drops at the next first byte
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shift <= '0;
            cnt <= '0;
            tcnt <= '0;
            cmd <= '0;
            cmd_rdy <= 1'b0;
            overrun <= 1'b0;
            frm_err <= 1'b0;
            unread <= 1'b0;
        end else begin
            frm_err <= expire;
            shift <= rx_rdy ? word : expire ? '0 : shift;
            cnt <= complete ? '0 : rx_rdy ? base + 1'b1 : expire ? '0 : cnt;
            tcnt <= (rx_rdy || expire || state == IDLE) ? '0 : tcnt + 1'b1;
            cmd <= complete ? word : cmd;
            cmd_rdy <= complete || (cmd_rdy && !clr_cmd_rdy && !first);
            overrun <= (overrun || (complete && unread)) && !clr_cmd_rdy;
            unread <= complete || (unread && !clr_cmd_rdy);
        end
    pkt_tx_serializer #(.RESP_BYTES(RESP_BYTES)) u_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .trmt         (trmt),
        .resp         (resp),
        .tx_byte_done (tx_byte_done),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done)
    );
endmodule

// File: tb/tb_uart_pkt_wrapper.sv
// tb_uart_pkt_wrapper: directed self-checking bench for a 3-byte command / 2-byte response wrapper
module tb_uart_pkt_wrapper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_rdy = 1'b0;
    logic clr_cmd_rdy = 1'b0;
    logic trmt = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic tx_byte_done;
    logic clr_rx_rdy, cmd_rdy, overrun, frm_err, tx_start, tx_done;
    logic [23:0] cmd;
    logic [7:0] tx_data;
    logic [7:0] tx_log[$];
    int n_chk = 0;
    int n_fail = 0;
    int lat4, lat6, wait_cyc;
    always #5 clk = ~clk;
    uart_pkt_wrapper #(.CMD_BYTES(3), .RESP_BYTES(2), .TIMEOUT_CYC(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .clr_rx_rdy   (clr_rx_rdy),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .overrun      (overrun),
        .frm_err      (frm_err),
        .trmt         (trmt),
        .resp         (resp),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_byte_done (tx_byte_done),
        .tx_done      (tx_done)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy = 1'b1;
        #1 check("clr_rx_rdy", clr_rx_rdy, 1);
        @(negedge clk);
        rx_rdy = 1'b0;
        #1;
    endtask
    task automatic clr_pulse();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        #1;
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_cmd_rdy"}, cmd_rdy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_frm_err"}, frm_err, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_done"}, tx_done, 0);
        check({tag, "_clr_rx_rdy"}, clr_rx_rdy, 0);
    endtask
    // Drives trmt and waits for tx_done; optionally fires an extra trmt mid-send that must be ignored
    task automatic run_tx(input logic [15:0] r, input bit inj, output int lat);
        logic last_done;
        last_done = 1'b0;
        lat = 0;
        @(negedge clk);
        resp = r;
        trmt = 1'b1;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(negedge clk);
            trmt = inj && c == 5;
            if (inj && c == 5) resp = 16'h1234;
            #1;
            if (c == 1) check("tx_done_cleared", tx_done, 0);
            if (tx_done) begin
                lat = c;
                check("tx_done_after_byte_done", last_done, 1);
            end
            last_done = tx_byte_done;
        end
        trmt = 1'b0;
        if (lat == 0) check("tx_done_timeout", 0, 1);
    endtask
    // UART transmitter model: acknowledges each byte 10 clocks after its tx_start
    initial begin
        tx_byte_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_byte_done = 1'b0;
            if (tx_start) begin
                repeat (10) @(negedge clk);
                tx_byte_done = 1'b1;
            end
        end
    end
    always @(negedge clk) if (rst_n && tx_start) tx_log.push_back(tx_data);
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        idle(3);
        #1 check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        // basic 3-byte assembly with wide spacing
        send_byte(8'h12);
        idle(19);
        send_byte(8'h34);
        check("t1_mid_cmd_rdy", cmd_rdy, 0);
        idle(19);
        send_byte(8'h56);
        check("t1_cmd", cmd, 24'h123456);
        check("t1_cmd_rdy", cmd_rdy, 1);
        check("t1_overrun", overrun, 0);
        clr_pulse();
        check("t1_cmd_rdy_clr", cmd_rdy, 0);
        // timeout resync
        send_byte(8'hAA);
        wait_cyc = 0;
        for (int c = 1; c <= 200 && wait_cyc == 0; c++) begin
            @(negedge clk);
            #1;
            if (frm_err) wait_cyc = c;
        end
        check("t2_frm_err_latency", wait_cyc, 101);
        check("t2_cmd_kept", cmd, 24'h123456);
        @(negedge clk);
        #1 check("t2_frm_err_one_cycle", frm_err, 0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("t2_cmd_resync", cmd, 24'h010203);
        check("t2_cmd_rdy", cmd_rdy, 1);
        check("t2_overrun", overrun, 0);
        clr_pulse();
        // byte on the expiry cycle starts a new command
        send_byte(8'h77);
        idle(99);
        send_byte(8'h55);
        check("t2_expiry_frm_err", frm_err, 1);
        send_byte(8'h66);
        send_byte(8'h44);
        check("t2_expiry_cmd", cmd, 24'h556644);
        clr_pulse();
        // overrun and clr colliding with completion
        send_byte(8'h11);
        send_byte(8'h11);
        send_byte(8'h11);
        check("t3_first_overrun", overrun, 0);
        send_byte(8'h22);
        check("t3_first_byte_clears_rdy", cmd_rdy, 0);
        send_byte(8'h22);
        send_byte(8'h22);
        check("t3_overrun", overrun, 1);
        check("t3_cmd_overwrite", cmd, 24'h222222);
        send_byte(8'h33);
        check("t3_overrun_sticky", overrun, 1);
        send_byte(8'h33);
        @(negedge clk);
        rx_data = 8'h33;
        rx_rdy = 1'b1;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        #1;
        check("t3_clr_collide_rdy", cmd_rdy, 1);
        check("t3_clr_collide_overrun", overrun, 0);
        check("t3_clr_collide_cmd", cmd, 24'h333333);
        clr_pulse();
        // two-byte response with an ignored mid-send trmt
        run_tx(16'hBEEF, 1'b1, lat4);
        check("t4_latency", lat4, 23);
        check("t4_nbytes", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            check("t4_byte0", tx_log[0], 8'hBE);
            check("t4_byte1", tx_log[1], 8'hEF);
        end
        idle(30);
        #1;
        check("t4_no_resend", tx_log.size(), 2);
        check("t4_tx_done_held", tx_done, 1);
        // concurrent RX and TX
        tx_log.delete();
        fork
            run_tx(16'hA55A, 1'b0, lat6);
            begin
                idle(2);
                send_byte(8'hCA);
                idle(4);
                send_byte(8'hFE);
                idle(4);
                send_byte(8'h01);
                check("t6_cmd", cmd, 24'hCAFE01);
                check("t6_cmd_rdy", cmd_rdy, 1);
                check("t6_overrun", overrun, 0);
            end
        join
        check("t6_latency", lat6, 23);
        check("t6_nbytes", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            check("t6_byte0", tx_log[0], 8'hA5);
            check("t6_byte1", tx_log[1], 8'h5A);
        end
        // reset mid-packet
        send_byte(8'h9A);
        send_byte(8'hBC);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset("t5_reset");
        idle(2);
        rst_n = 1'b1;
        send_byte(8'h9A);
        send_byte(8'hBC);
        send_byte(8'hDE);
        check("t5_cmd", cmd, 24'h9ABCDE);
        check("t5_cmd_rdy", cmd_rdy, 1);
        check("t5_overrun", overrun, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
